// File: rtl/qubit_measure.sv
// -----------------------------------------------------------------------------
// qubit_measure
//
// Readout stage at the tail of the gate pipeline. It accepts one qubit's
// amplitude pair (alpha, beta) and squares each amplitude on one shared
// multiplier over two cycles. It then compares a scaled pseudo-random draw
// against |alpha|^2 and emits the measured bit together with the collapsed
// basis state.
//
// Build option:
//   QMEAS_RAND_OVERRIDE_EN  adds rand_ovr_en / rand_ovr. These let an external
//                           value replace the LFSR sample in CMP. Leave this
//                           undefined for production builds.
//
// Parameter WIDTH defaults to the FIXED_WIDTH macro, or to 16 if that macro
// is not defined.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     amplitude pair valid
//   in_ready     block can accept a pair (IDLE only)
//   in_alpha     signed |0> amplitude, FRAC_BITS fractional bits
//   in_beta      signed |1> amplitude, FRAC_BITS fractional bits
//   out_valid    result valid; held until out_ready
//   out_ready    downstream accepts result
//   out_bit      measured outcome
//   out_alpha    collapsed |0> amplitude (ONE or 0)
//   out_beta     collapsed |1> amplitude (0 or ONE)
//   out_err      both input amplitudes were zero
//   rand_ovr_en  (option) use rand_ovr instead of the LFSR sample
//   rand_ovr     (option) override sample
// -----------------------------------------------------------------------------
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif

module qubit_measure #(
    parameter int          WIDTH     = `FIXED_WIDTH,
    parameter int          FRAC_BITS = 14,
    parameter int          RAND_W    = 16,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_alpha,
    input  logic signed [WIDTH-1:0] in_beta,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_bit,
    output logic [WIDTH-1:0]        out_alpha,
    output logic [WIDTH-1:0]        out_beta,
    output logic                    out_err
`ifdef QMEAS_RAND_OVERRIDE_EN
    ,
    input  logic                    rand_ovr_en,
    input  logic [RAND_W-1:0]       rand_ovr
`endif
);

    // state | meaning
    // IDLE  | waiting for an amplitude pair, in_ready high
    // SQA   | multiplier forms alpha^2 into p0
    // SQB   | multiplier forms beta^2 into p1
    // CMP   | draw sample, decide outcome, register results
    // OUT   | out_valid high, outputs held until out_ready
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQA  = 3'd1,
        SQB  = 3'd2,
        CMP  = 3'd3,
        OUT  = 3'd4
    } state_t;

    localparam int PW = 2 * WIDTH;          // square width
    localparam int TW = PW + 1;             // p0 + p1 width
    localparam int MW = TW + RAND_W;        // total * r width
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC_BITS;

    state_t state;
    state_t state_nx;

    logic signed [WIDTH-1:0] alpha_q;
    logic signed [WIDTH-1:0] beta_q;
    logic [PW-1:0]           p0_q;
    logic [PW-1:0]           p1_q;
    logic [15:0]             lfsr_q;
    logic [15:0]             lfsr_nx;

    logic signed [WIDTH-1:0] mult_a;
    logic signed [PW-1:0]    mult_ext;
    logic signed [PW-1:0]    sq_s;
    logic [PW-1:0]           sq;

    logic [TW-1:0]           total;
    logic [RAND_W-1:0]       r_lfsr;
    logic [RAND_W-1:0]       r_sel;
    logic [MW-1:0]           prod;
    logic [TW-1:0]           thr;
    logic                    total_zero;
    logic                    cmp_bit;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        mult_a    = alpha_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = SQA;
                end
            end
            SQA: begin
                state_nx = SQB;
            end
            SQB: begin
                mult_a   = beta_q;
                state_nx = CMP;
            end
            CMP: begin
                state_nx = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shared squarer. A signed square is never negative. It fits in PW
    // bits even for the most negative input (2^(2W-2)).
    // ------------------------------------------------------------------
    assign mult_ext = PW'(mult_a);
    assign sq_s     = mult_ext * mult_ext;
    assign sq       = sq_s;

    // ------------------------------------------------------------------
    // LFSR: 16-bit Galois, x^16+x^14+x^13+x^11+1. It free-runs every
    // clock, including stalls, and the nonzero seed keeps it off zero.
    // ------------------------------------------------------------------
    assign lfsr_nx = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

    generate
        if (RAND_W <= 16) begin : g_rand_narrow
            assign r_lfsr = lfsr_q[RAND_W-1:0];
        end else begin : g_rand_wide
            assign r_lfsr = {{(RAND_W - 16){1'b0}}, lfsr_q};
        end
    endgenerate

`ifdef QMEAS_RAND_OVERRIDE_EN
    assign r_sel = rand_ovr_en ? rand_ovr : r_lfsr;
`else
    assign r_sel = r_lfsr;
`endif

    // ------------------------------------------------------------------
    // Decision. thr scales the sample into [0, total). The outcome is |1>
    // once thr passes the |0> share p0, so P(1) = p1/total.
    // ------------------------------------------------------------------
    assign total      = {1'b0, p0_q} + {1'b0, p1_q};
    assign prod       = {{RAND_W{1'b0}}, total} * {{TW{1'b0}}, r_sel};
    assign thr        = prod[MW-1:RAND_W];
    assign total_zero = (total == '0);
    assign cmp_bit    = !total_zero && (thr >= {1'b0, p0_q});

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            alpha_q   <= '0;
            beta_q    <= '0;
            p0_q      <= '0;
            p1_q      <= '0;
            lfsr_q    <= SEED;
            out_bit   <= 1'b0;
            out_alpha <= '0;
            out_beta  <= '0;
            out_err   <= 1'b0;
        end else begin
            lfsr_q <= lfsr_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        alpha_q <= in_alpha;
                        beta_q  <= in_beta;
                    end
                end
                SQA: begin
                    p0_q <= sq;
                end
                SQB: begin
                    p1_q <= sq;
                end
                CMP: begin
                    // Phase is discarded: the collapsed state is a pure basis vector.
                    out_bit   <= cmp_bit;
                    out_err   <= total_zero;
                    out_alpha <= cmp_bit ? '0 : ONE;
                    out_beta  <= cmp_bit ? ONE : '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qubit_measure.sv
// -----------------------------------------------------------------------------
// tb_qubit_measure
//
// Directed bench for qubit_measure (WIDTH=16, FRAC_BITS=14). The bench keeps
// its own copy of the LFSR so that it can predict outcomes from the free-running
// sample. Override cases are exercised when QMEAS_RAND_OVERRIDE_EN is defined.
// -----------------------------------------------------------------------------
module tb_qubit_measure;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] ONE  = 16'd16384;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_alpha;
    logic signed [15:0] in_beta;
    logic               out_valid;
    logic               out_ready;
    logic               out_bit;
    logic [15:0]        out_alpha;
    logic [15:0]        out_beta;
    logic               out_err;
`ifdef QMEAS_RAND_OVERRIDE_EN
    logic               rand_ovr_en;
    logic [15:0]        rand_ovr;
`endif

    int   n_total = 0;
    int   n_bad   = 0;
    logic last_bit;
    logic bit_a;
    logic [15:0] m_lfsr;

    qubit_measure #(
        .WIDTH    (16),
        .FRAC_BITS(14),
        .RAND_W   (16),
        .SEED     (SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_alpha   (in_alpha),
        .in_beta    (in_beta),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bit    (out_bit),
        .out_alpha  (out_alpha),
        .out_beta   (out_beta),
        .out_err    (out_err)
`ifdef QMEAS_RAND_OVERRIDE_EN
        ,
        .rand_ovr_en(rand_ovr_en),
        .rand_ovr   (rand_ovr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference sample generator: x^16+x^14+x^13+x^11+1, Galois form
    always @(posedge clk) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input logic signed [15:0] a, input logic signed [15:0] b,
                                     input logic [15:0] r);
        longint aa, bb, p0, p1, tot, thr;
        aa  = a;
        bb  = b;
        p0  = aa * aa;
        p1  = bb * bb;
        tot = p0 + p1;
        thr = (tot * longint'(r)) >>> 16;
        if (tot == 0) return 1'b0;
        return (thr >= p0);
    endfunction

    // One full transaction. stall > 0 holds out_ready low for that many
    // cycles in OUT before releasing it.
    task automatic run(input logic signed [15:0] a, input logic signed [15:0] b,
                       input bit oen, input logic [15:0] ov, input int stall);
        logic [15:0] r;
        logic        eb;
        int          n;
        in_alpha  = a;
        in_beta   = b;
`ifdef QMEAS_RAND_OVERRIDE_EN
        rand_ovr_en = oen;
        rand_ovr    = ov;
`endif
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_ready", in_ready, 1);
        @(posedge clk); #1;              // accepting edge -> SQA
        in_valid = 1'b0;
        chk("busy_ready", in_ready, 0);
        @(posedge clk);
        @(posedge clk); #1;              // CMP
        chk("cmp_valid", out_valid, 0);
`ifdef QMEAS_RAND_OVERRIDE_EN
        r = oen ? ov : m_lfsr;
`else
        r = m_lfsr;
`endif
        eb = exp_bit(a, b, r);
        @(posedge clk); #1;              // OUT
        chk("out_valid", out_valid, 1);
        chk("out_bit",   out_bit,   eb);
        chk("out_alpha", out_alpha, eb ? 16'd0 : ONE);
        chk("out_beta",  out_beta,  eb ? ONE : 16'd0);
        chk("out_err",   out_err,   (a == 0 && b == 0));
        chk("out_ready_lo", in_ready, 0);
        last_bit = out_bit;
        if (stall > 0) begin
            // Offer a different pair during the stall; it must be ignored.
            in_alpha = 16'sd0;
            in_beta  = 16'sd0;
            in_valid = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                chk("stall_valid", out_valid, 1);
                chk("stall_bit",   out_bit,   eb);
                chk("stall_alpha", out_alpha, eb ? 16'd0 : ONE);
                chk("stall_ready", in_ready,  0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("ret_ready", in_ready,  1);
        chk("ret_valid", out_valid, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_alpha  = '0;
        in_beta   = '0;
        out_ready = 1'b1;
`ifdef QMEAS_RAND_OVERRIDE_EN
        rand_ovr_en = 1'b0;
        rand_ovr    = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", in_ready,  1);
        chk("rst_valid", out_valid, 0);
        chk("rst_bit",   out_bit,   0);
        chk("rst_alpha", out_alpha, 0);
        chk("rst_beta",  out_beta,  0);
        chk("rst_err",   out_err,   0);
        rst = 1'b0;

        // Pure |0>: the outcome is always 0 whatever the sample.
        for (int i = 0; i < 200; i++) begin
            run(16'sd16384, 16'sd0, 1'b0, 16'h0000, 0);
        end

        // Equal superposition, outcome follows the free-running sample.
        for (int i = 0; i < 20; i++) begin
            run(16'sd16384, 16'sd16384, 1'b0, 16'h0000, 0);
        end
        // Unequal weights, cos/sin(60 deg).
        for (int i = 0; i < 20; i++) begin
            run(16'sd8192, 16'sd14189, 1'b0, 16'h0000, 0);
        end

        // Threshold edge for equal weights: thr = r * 2^13 against p0 = 2^28.
        run(16'sd16384, 16'sd16384, 1'b1, 16'h7FFF, 0);
`ifdef QMEAS_RAND_OVERRIDE_EN
        chk("half_below", last_bit, 0);
`endif
        run(16'sd16384, 16'sd16384, 1'b1, 16'h8000, 0);
`ifdef QMEAS_RAND_OVERRIDE_EN
        chk("half_at", last_bit, 1);
`endif

        // Zero norm, then a normal pair clears out_err.
        run(16'sd0, 16'sd0, 1'b1, 16'h8000, 0);
        run(-16'sd16384, 16'sd0, 1'b1, 16'hFFFF, 0);

        // Input sign is irrelevant.
        run(-16'sd11585, 16'sd11585, 1'b1, 16'h8000, 0);
        bit_a = last_bit;
        run(16'sd11585, 16'sd11585, 1'b1, 16'h8000, 0);
        chk("sign_inv", last_bit, bit_a);
        run(-16'sd32768, -16'sd32768, 1'b1, 16'h4000, 0);

        // Ten-cycle stall in OUT.
        run(16'sd8192, 16'sd14189, 1'b1, 16'hC000, 10);

        // Reset while in SQB: no result, reset values on the next edge.
        in_alpha = 16'sd16384;
        in_beta  = 16'sd16384;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;                 // SQA
        @(posedge clk); #1;              // SQB
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready,  1);
        chk("mid_rst_bit",   out_bit,   0);
        chk("mid_rst_alpha", out_alpha, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("post_rst_valid", out_valid, 0);
        end
        // Reference LFSR restarted from SEED too, so this checks the reseed.
        for (int i = 0; i < 8; i++) begin
            run(16'sd16384, 16'sd16384, 1'b0, 16'h0000, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
